// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, stage indices and NOP encoding for the pipeline controller.
// Pure declarations: no latency, no flow control.
package pipe_ctrl_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int NSTAGE_DEF   = 5;
  localparam int EX_STAGE_DEF = 2;
  localparam int MC_LAT_DEF   = 4;
  localparam int RA_W_DEF     = 5;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  // Instruction loaded into a flushed pipeline register (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/jump request bundle from the datapath and the stall/flush/redirect response.
// Wires only: no latency, no flow control of its own.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NSTAGE = NSTAGE_DEF,
  parameter int RA_W   = RA_W_DEF
);

  logic [NSTAGE-1:0] hold_req_i;
  logic              jump_en_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic              ld_valid_i;
  logic [RA_W-1:0]   ld_rd_addr_i;
  logic [RA_W-1:0]   id_rs1_addr_i;
  logic [RA_W-1:0]   id_rs2_addr_i;
  logic              mc_start_i;
  logic [NSTAGE-1:0] stall_o;
  logic [NSTAGE-1:0] flush_o;
  logic              pc_jump_en_o;
  logic [ADDR_W-1:0] pc_jump_addr_o;
  logic              mc_busy_o;

  modport master (
    output hold_req_i, jump_en_i, jump_addr_i, ld_valid_i, ld_rd_addr_i,
           id_rs1_addr_i, id_rs2_addr_i, mc_start_i,
    input  stall_o, flush_o, pc_jump_en_o, pc_jump_addr_o, mc_busy_o
  );

  modport slave (
    input  hold_req_i, jump_en_i, jump_addr_i, ld_valid_i, ld_rd_addr_i,
           id_rs1_addr_i, id_rs2_addr_i, mc_start_i,
    output stall_o, flush_o, pc_jump_en_o, pc_jump_addr_o, mc_busy_o
  );

endinterface

// File: rtl/pipe_ctrl_mc_counter.sv
// Down-counter tracking the remaining cycles of a multi-cycle EX op.
// Busy from the cycle after start; a start while busy is ignored.
module mc_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_LAT = MC_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic [$clog2(MC_LAT)-1:0] cnt_o
);

  localparam int CNT_W = $clog2(MC_LAT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else if (start_i) begin
      // The start cycle itself stalls EX, so only MC_LAT-1 further cycles remain.
      cnt_d = CNT_W'(MC_LAT - 1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges holds, load-use, multi-cycle ops and jumps into stall/flush vectors.
// Jumps redirect combinationally; a jump seen while EX stalls is held and issued once EX frees.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NSTAGE   = NSTAGE_DEF,
  parameter int EX_STAGE = EX_STAGE_DEF,
  parameter int MC_LAT   = MC_LAT_DEF,
  parameter int RA_W     = RA_W_DEF
) (
  input  logic     clk,
  input  logic     rst,
  pipe_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(MC_LAT);

  logic              mc_busy;
  logic [CNT_W-1:0]  mc_cnt;
  logic              mc_go;
  logic [NSTAGE-1:0] req;
  logic [NSTAGE-1:0] stall;
  logic [NSTAGE-1:0] flush;
  logic              ex_stalled;
  logic              jt;
  logic              lu;

  logic              pend_en_q;
  logic              pend_en_d;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [ADDR_W-1:0] pend_addr_d;

  mc_counter #(.MC_LAT(MC_LAT)) u_mc_counter (
    .clk     (clk),
    .rst     (rst),
    .start_i (bus.mc_start_i),
    .busy_o  (mc_busy),
    .cnt_o   (mc_cnt)
  );

  always_comb begin
    req           = bus.hold_req_i;
    mc_go         = bus.mc_start_i & (mc_cnt == '0);
    req[EX_STAGE] = req[EX_STAGE] | mc_busy | mc_go;

    // EX-and-downstream stall never depends on the load-use term, so jt can be resolved first.
    ex_stalled = |req[NSTAGE-1:EX_STAGE];
    jt         = (bus.jump_en_i | pend_en_q) & ~ex_stalled;

    lu = bus.ld_valid_i & (bus.ld_rd_addr_i != '0) &
         ((bus.ld_rd_addr_i == bus.id_rs1_addr_i) |
          (bus.ld_rd_addr_i == bus.id_rs2_addr_i)) & ~jt;
    req[EX_STAGE-1] = req[EX_STAGE-1] | lu;

    stall[NSTAGE-1] = req[NSTAGE-1];
    for (int k = NSTAGE - 2; k >= 0; k--) begin
      stall[k] = req[k] | stall[k+1];
    end

    flush = '0;
    for (int k = 1; k < NSTAGE; k++) begin
      flush[k] = stall[k-1] & ~stall[k];
    end

    if (jt) begin
      for (int k = 0; k <= EX_STAGE; k++) begin
        stall[k] = 1'b0;
        flush[k] = 1'b1;
      end
    end
  end

  always_comb begin
    pend_en_d   = pend_en_q;
    pend_addr_d = pend_addr_q;
    if (jt) begin
      pend_en_d = 1'b0;
    end else if (bus.jump_en_i & ex_stalled & ~pend_en_q) begin
      pend_en_d   = 1'b1;
      pend_addr_d = bus.jump_addr_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_en_q   <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      pend_en_q   <= pend_en_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  // Outputs are forced low during reset, including the combinational pass-through paths.
  assign bus.stall_o        = rst ? stall : '0;
  assign bus.flush_o        = rst ? flush : '0;
  assign bus.pc_jump_en_o   = rst & jt;
  assign bus.pc_jump_addr_o = rst ? (pend_en_q ? pend_addr_q : bus.jump_addr_i) : '0;
  assign bus.mc_busy_o      = rst & mc_busy;

endmodule
